// File: rtl/data_mem_lsu_if.sv
// Request/response and data-memory bus between the core, the load/store unit and the memory.
// The slave view belongs to the LSU; master is the requesting core; mem is the memory side.
interface data_mem_lsu_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_store;
  logic [2:0]            req_funct3;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;

  logic                  rsp_valid;
  logic                  rsp_err;
  logic [DATA_WIDTH-1:0] rsp_rdata;

  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_w_en;
  logic [DATA_WIDTH-1:0] mem_w_data;
  logic [DATA_WIDTH-1:0] mem_r_data;

  modport master (
    output req_valid, req_store, req_funct3, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_err, rsp_rdata
  );

  modport slave (
    input  req_valid, req_store, req_funct3, req_addr, req_wdata, mem_r_data,
    output req_ready, rsp_valid, rsp_err, rsp_rdata, mem_addr, mem_w_en, mem_w_data
  );

  modport mem (
    input  mem_addr, mem_w_en, mem_w_data,
    output mem_r_data
  );
endinterface

// File: rtl/data_mem_lsu.sv
// Load/store unit for a word-wide single-port data memory without byte enables.
// Sub-word stores are done as read-modify-write; misaligned/illegal accesses return an error.
module data_mem_lsu #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
) (
  input logic           clk,
  input logic           reset,
  data_mem_lsu_if.slave bus
);

  localparam logic [2:0] F3B  = 3'b000;
  localparam logic [2:0] F3H  = 3'b001;
  localparam logic [2:0] F3W  = 3'b010;
  localparam logic [2:0] F3BU = 3'b100;
  localparam logic [2:0] F3HU = 3'b101;

  typedef enum logic [2:0] {
    StIdle,
    StRd,
    StCap,
    StMerge,
    StWr,
    StResp
  } state_e;

  state_e                state_q;
  logic                  store_q;
  logic [2:0]            funct3_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  rsp_err_q;
  logic [DATA_WIDTH-1:0] rsp_rdata_q;

  logic                  legal;
  logic [7:0]            ld_byte;
  logic [15:0]           ld_half;
  logic [DATA_WIDTH-1:0] ld_ext;
  logic [DATA_WIDTH-1:0] merged;

  // Legality is judged on the live request so an illegal access never leaves IDLE for memory.
  always_comb begin
    legal = 1'b0;
    unique case (bus.req_funct3)
      F3B:     legal = 1'b1;
      F3H:     legal = ~bus.req_addr[0];
      F3W:     legal = (bus.req_addr[1:0] == 2'b00);
      F3BU:    legal = ~bus.req_store;
      F3HU:    legal = ~bus.req_store & ~bus.req_addr[0];
      default: legal = 1'b0;
    endcase
  end

  always_comb begin
    ld_byte = bus.mem_r_data[{addr_q[1:0], 3'b000} +: 8];
    ld_half = addr_q[1] ? bus.mem_r_data[31:16] : bus.mem_r_data[15:0];
    ld_ext  = bus.mem_r_data;
    unique case (funct3_q)
      F3B:     ld_ext = {{24{ld_byte[7]}}, ld_byte};
      F3H:     ld_ext = {{16{ld_half[15]}}, ld_half};
      F3BU:    ld_ext = {24'h000000, ld_byte};
      F3HU:    ld_ext = {16'h0000, ld_half};
      default: ld_ext = bus.mem_r_data;
    endcase
  end

  // Only SB/SH reach MERGE, so funct3[0] alone picks byte vs half lane.
  always_comb begin
    merged = bus.mem_r_data;
    if (funct3_q[0] == 1'b0) begin
      merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
    end else begin
      merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      store_q     <= 1'b0;
      funct3_q    <= 3'b000;
      addr_q      <= '0;
      wdata_q     <= '0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.req_valid) begin
            store_q  <= bus.req_store;
            funct3_q <= bus.req_funct3;
            addr_q   <= bus.req_addr;
            wdata_q  <= bus.req_wdata;
            if (!legal) begin
              rsp_err_q   <= 1'b1;
              rsp_rdata_q <= '0;
              state_q     <= StResp;
            end else if (bus.req_store && (bus.req_funct3 == F3W)) begin
              state_q <= StWr;
            end else begin
              state_q <= StRd;
            end
          end
        end
        StRd: begin
          state_q <= store_q ? StMerge : StCap;
        end
        StCap: begin
          rsp_err_q   <= 1'b0;
          rsp_rdata_q <= ld_ext;
          state_q     <= StResp;
        end
        StMerge, StWr: begin
          rsp_err_q   <= 1'b0;
          rsp_rdata_q <= '0;
          state_q     <= StResp;
        end
        StResp: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  // Write enable and response strobe are pure state decodes, so reset kills them at once.
  assign bus.req_ready  = (state_q == StIdle);
  assign bus.rsp_valid  = (state_q == StResp);
  assign bus.rsp_err    = rsp_err_q;
  assign bus.rsp_rdata  = rsp_rdata_q;
  assign bus.mem_addr   = addr_q;
  assign bus.mem_w_en   = (state_q == StWr) || (state_q == StMerge);
  assign bus.mem_w_data = (state_q == StMerge) ? merged : wdata_q;

endmodule

// File: doc/data_mem_lsu.md
Name: data_mem_lsu

Overview:
Load/store initiator that drives the single-port data memory on behalf of the RV32IM core.
- Memory is word-wide with no byte enables, synchronous address, unregistered read output: q valid the cycle after the address is clocked.
- Unit implements LB/LH/LW/LBU/LHU with lane select and sign/zero extension.
- SW is a direct write. SB/SH use read-modify-write.
- Sits between the core's execute stage and the data memory; reports misaligned or illegal accesses instead of issuing them.

Parameters:
- ADDR_WIDTH, 32, width of req_addr and mem_addr (byte address; memory drops bits [1:0]).
- DATA_WIDTH, 32, data width; only 32 supported.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- req_valid  input  1  access request, sampled when req_ready=1.
- req_ready  output  1  high only in IDLE.
- req_store  input  1  1=store, 0=load.
- req_funct3  input  3  RV32 funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- req_addr  input  ADDR_WIDTH  byte address.
- req_wdata  input  DATA_WIDTH  store data, low bytes used for B/H.
- rsp_valid  output  1  one-cycle completion pulse.
- rsp_err  output  1  valid with rsp_valid; 1 = misaligned or illegal funct3.
- rsp_rdata  output  DATA_WIDTH  extended load result, valid with rsp_valid.
- mem_addr  output  ADDR_WIDTH  byte address to data memory.
- mem_w_en  output  1  memory write enable.
- mem_w_data  output  DATA_WIDTH  memory write data.
- mem_r_data  input  DATA_WIDTH  memory read data (q).

Behaviour:
- Reset values (async): state=IDLE; req_ready=1; rsp_valid=0; rsp_err=0; rsp_rdata=0; mem_addr=0; mem_w_en=0; mem_w_data=0.
- Accept: req_valid && req_ready at edge E0.
  - Latch store, funct3, addr, wdata.
  - mem_addr driven from latched addr and held until the next accept.
- Legality:
  - H/HU need addr[0]=0; W needs addr[1:0]=0.
  - Funct3 011/110/111 is illegal for loads and stores; 100/101 is illegal for stores.
  - Illegal access: E0 -> RESP with rsp_err=1, rsp_rdata=0, no memory access.
- States:
  - IDLE: req_ready=1, mem_w_en=0. Legal SW -> WR; other legal access -> RD; illegal -> RESP.
  - RD: mem_w_en=0; memory clocks the address at E1. Load -> CAP; SB/SH -> MERGE.
  - CAP: mem_r_data valid. At E2 register the result into rsp_rdata -> RESP.
    - Lane = addr[1:0] for bytes, addr[1] for halves (little-endian).
    - B/H sign-extend; BU/HU zero-extend; W passes through.
  - MERGE: mem_w_en=1. mem_w_data = mem_r_data with the selected byte/half lane replaced by req_wdata[7:0]/[15:0]. Write at E2 -> RESP.
  - WR: mem_w_en=1, mem_w_data=req_wdata. Write at E1 -> RESP.
  - RESP: rsp_valid=1 for exactly one cycle -> IDLE. No backpressure; new request accepted the cycle after RESP.
- Latency (accept edge to the cycle with rsp_valid):
  - Loads and SB/SH: 3 cycles.
  - SW: 2 cycles.
  - Illegal access: 1 cycle.
- Output timing:
  - mem_w_en and rsp_valid decode from state only.
  - rsp_err/rsp_rdata hold until the next RESP.
- Exactly one memory write per store; none for loads or errors.
- Reset mid-operation: IDLE immediately, mem_w_en drops asynchronously, no write completes, no rsp_valid.
- req_valid while busy is ignored (req_ready=0); requester must hold.

Test Plan:
- Preload word 0x10 = 0x8899AABB; LB addr 0x11 -> rsp_rdata=0xFFFFFFAA, err=0, rsp_valid 3 cycles after accept; LBU 0x11 -> 0x000000AA.
- LH 0x12 -> 0xFFFF8899; LHU 0x12 -> 0x00008899; LW 0x10 -> 0x8899AABB.
- SB 0x13 wdata 0x12345677 -> exactly one write pulse, word 0x7799AABB; then SH 0x10 wdata 0x0000CAFE -> 0x7799CAFE; read back via LW.
- SW 0x14 wdata 0xDEADBEEF -> mem_w_en one cycle, rsp_valid 2 cycles after accept, LW 0x14 = 0xDEADBEEF.
- LW 0x12, SH 0x11, store funct3=100 -> rsp_err=1 one cycle after accept, mem_w_en never asserted, memory unchanged.
- Assert reset in MERGE of SB 0x10 -> mem_w_en falls immediately, word unchanged, no rsp_valid, req_ready=1 after release; back-to-back requests with req_valid held high each complete in order.
